mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 145 ++++++++++++++
 tb/tb_mul_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter that shares one multiplier among N_REQ
// requesters. Each operation runs IDLE -> ISSUE -> WAIT -> DELIVER, so the
// multiplier only ever has one operation in flight.
// Optional build macro: MUL_ARB_TIMEOUT_EN adds a WAIT watchdog. When it
// expires, the arbiter delivers y_out=0 and pulses err together with y_valid.
module mul_arbiter #(
  parameter int C_WIDTH        = 8,
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       ctl_clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*C_WIDTH-1:0]   a_in,
  input  logic [N_REQ*C_WIDTH-1:0]   b_in,
  output logic [N_REQ-1:0]           grant,
  output logic [C_WIDTH-1:0]         y_out,
  output logic [N_REQ-1:0]           y_valid,
  output logic                       err,
  output logic                       busy,
  output logic [C_WIDTH-1:0]         mul_a,
  output logic [C_WIDTH-1:0]         mul_b,
  output logic                       mul_trigger,
  input  logic                       mul_ready,
  input  logic                       mul_done,
  input  logic [C_WIDTH-1:0]         mul_y
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [N_REQ-1:0] sel_oh;
  logic            timeout;

  assign sel_oh = N_REQ'(1) << sel;

  // Round-robin search: first requester after last_grant, wrapping to 0.
  always_comb begin
    logic [IW-1:0] j;
    j        = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = IW'((int'(last_grant) + k) % N_REQ);
      if (!pick_vld && req[j]) begin
        pick_vld = 1'b1;
        pick     = j;
      end
    end
  end

  // State register.
  always_ff @(posedge ctl_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-state pulse outputs.
  always_comb begin
    state_nxt   = state;
    grant       = '0;
    y_valid     = '0;
    busy        = 1'b1;
    mul_trigger = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (pick_vld && mul_ready) state_nxt = ISSUE;
      end
      ISSUE: begin
        grant       = sel_oh;
        mul_trigger = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (mul_done || timeout) state_nxt = DELIVER;
      end
      DELIVER: begin
        y_valid   = sel_oh;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch at acceptance, result capture in WAIT, priority update on delivery.
  always_ff @(posedge ctl_clk) begin
    if (reset) begin
      sel        <= '0;
      last_grant <= IW'(N_REQ - 1);
      mul_a      <= '0;
      mul_b      <= '0;
      y_out      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld && mul_ready) begin
            sel   <= pick;
            mul_a <= a_in[int'(pick)*C_WIDTH +: C_WIDTH];
            mul_b <= b_in[int'(pick)*C_WIDTH +: C_WIDTH];
          end
        end
        WAIT: begin
          if (mul_done)     y_out <= mul_y;
          else if (timeout) y_out <= '0;
        end
        DELIVER: last_grant <= sel;
        default: ;
      endcase
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;
  logic          to_flag;

  assign timeout = (state == WAIT) && !mul_done && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign err     = (state == DELIVER) && to_flag;

  // WAIT watchdog; to_flag marks that the coming delivery is an abort.
  always_ff @(posedge ctl_clk) begin
    if (reset) begin
      wait_cnt <= '0;
      to_flag  <= 1'b0;
    end else begin
      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      else               wait_cnt <= '0;
      if (timeout)               to_flag <= 1'b1;
      else if (state == DELIVER) to_flag <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a multiplier stub and a
// transaction-level reference model (round-robin order, products, pulses).
module tb_mul_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [N-1:0]       req = '0;
  logic [N*W-1:0]     a_in = '0;
  logic [N*W-1:0]     b_in = '0;
  logic [N-1:0]       grant;
  logic [W-1:0]       y_out;
  logic [N-1:0]       y_valid;
  logic               err;
  logic               busy;
  logic [W-1:0]       mul_a;
  logic [W-1:0]       mul_b;
  logic               mul_trigger;
  logic               mul_ready = 1'b1;
  logic               mul_done = 1'b0;
  logic [W-1:0]       mul_y = '0;

  always #5 clk = ~clk;

  mul_arbiter #(.C_WIDTH(W), .N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .ctl_clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .grant(grant), .y_out(y_out), .y_valid(y_valid), .err(err), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_trigger(mul_trigger),
    .mul_ready(mul_ready), .mul_done(mul_done), .mul_y(mul_y)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state (transaction level).
  bit           outstanding = 0;
  bit           dlv_last = 0;
  int           last_served = N - 1;
  int           cur = 0;
  int           since = 0;
  logic [W-1:0] ea, eb, ey;
  int           glog[$];
  int           vlog_idx[$];
  logic [W-1:0] vlog_y[$];
  bit           contin = 0;
  bit           rnd_mode = 0;
  bit           stub_off = 0;
  int           force_lat = 0;
  int           cnt_stub = 0;

  function automatic int rr(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req[i]         = 1'b1;
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  // One clock: capture inputs seen by the edge, check outputs at the negedge,
  // update the model, run the multiplier stub and requester behaviour.
  task automatic cycle();
    logic [N-1:0] req_s = req;
    bit           rdy_s = mul_ready;
    bit           done_s = mul_done;
    bit           rst_s = reset;
    bit           can = !outstanding && !dlv_last;
    bit           was_out;
    bit           exp_err;
    int           idx;
    logic [N-1:0] eg, ev;
    logic [2*W-1:0] prod;
    @(negedge clk);
    eg = '0;
    ev = '0;
    if (rst_s) begin
      outstanding = 0;
      dlv_last    = 0;
      last_served = N - 1;
      chk("rst_grant", grant, 0);
      chk("rst_y_valid", y_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_trigger", mul_trigger, 0);
      chk("rst_y_out", y_out, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
    end else begin
      was_out = outstanding;
      exp_err = 0;
      if (outstanding) since++;
      if (can && rdy_s && req_s != '0) begin
        idx = rr(req_s, last_served);
        eg  = N'(1) << idx;
      end
      if (outstanding && done_s) ev = N'(1) << cur;
`ifdef MUL_ARB_TIMEOUT_EN
      else if (outstanding && stub_off && since == TMO + 1) begin
        ev      = N'(1) << cur;
        ey      = '0;
        exp_err = 1;
      end
`endif
      chk("grant", grant, eg);
      chk("y_valid", y_valid, ev);
      chk("err", err, exp_err);
      chk("trigger", mul_trigger, eg != '0);
      chk("busy", busy, (eg != '0) || was_out);
      if (ev != '0) begin
        chk("y_out", y_out, ey);
        vlog_idx.push_back(cur);
        vlog_y.push_back(y_out);
        outstanding = 0;
        dlv_last    = 1;
        last_served = cur;
      end else begin
        dlv_last = 0;
      end
      if (eg != '0) begin
        cur  = idx;
        ea   = a_in[idx*W +: W];
        eb   = b_in[idx*W +: W];
        prod = ea * eb;
        ey   = prod[W-1:0];
        outstanding = 1;
        since = 0;
        glog.push_back(idx);
        if (contin) set_op(idx, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        else        req[idx] = 1'b0;
      end
      if (eg != '0 || was_out) begin
        chk("mul_a", mul_a, ea);
        chk("mul_b", mul_b, eb);
      end
    end
    // Multiplier stub: answers a trigger after 1..4 cycles with the product of its pins.
    mul_done = 1'b0;
    if (mul_trigger && !stub_off) begin
      cnt_stub = (force_lat > 0) ? force_lat : $urandom_range(1, 4);
    end else if (cnt_stub > 0) begin
      cnt_stub--;
      if (cnt_stub == 0) begin
        mul_done = 1'b1;
        mul_y    = W'(mul_a * mul_b);
      end
    end
    if (rnd_mode) begin
      mul_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0)
          set_op(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        else if (req[i] && $urandom_range(0, 15) == 0)
          req[i] = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    mul_ready = 1'b1;
    contin    = 0;
    rnd_mode  = 0;
    glog.delete();
    vlog_idx.delete();
    vlog_y.delete();
    cycle();
    reset = 1'b0;
  endtask

  task automatic wait_grants(input int target, input int budget);
    int c = 0;
    while (glog.size() < target && c < budget) begin
      cycle();
      c++;
    end
    chk("grant_wait", glog.size() >= target, 1);
  endtask

  initial begin
    // Reset state and single operation 3*2.
    do_reset();
    set_op(0, 8'h03, 8'h02);
    run(12);
    chk("t028_count", vlog_idx.size(), 1);
    if (vlog_idx.size() == 1) begin
      chk("t028_idx", vlog_idx[0], 0);
      chk("t028_y", vlog_y[0], 8'h06);
    end

    // Simultaneous requests 0 and 2.
    do_reset();
    set_op(0, 8'd5, 8'd7);
    set_op(2, 8'd9, 8'd11);
    run(25);
    chk("t029_count", vlog_idx.size(), 2);
    if (vlog_idx.size() == 2) begin
      chk("t029_first", glog[0], 0);
      chk("t029_second", glog[1], 2);
      chk("t029_y0", vlog_y[0], 8'h23);
      chk("t029_y1", vlog_y[1], 8'h63);
    end

    // All requesters held high continuously.
    do_reset();
    contin = 1;
    for (int i = 0; i < N; i++) set_op(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    wait_grants(5, 100);
    contin = 0;
    if (glog.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("t030_order%0d", i), glog[i], i % N);
    end
    req = '0;
    run(12);

    // Reset during WAIT; the late mul_done must be ignored.
    do_reset();
    force_lat = 4;
    set_op(1, 8'd4, 8'd5);
    wait_grants(1, 10);
    run(2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    run(8);
    chk("t031_no_late_valid", vlog_idx.size(), 0);
    force_lat = 0;

    // mul_ready low blocks acceptance.
    do_reset();
    mul_ready = 1'b0;
    set_op(1, 8'd6, 8'd7);
    run(5);
    chk("t032_no_grant", glog.size(), 0);
    mul_ready = 1'b1;
    cycle();
    chk("t032_grant_now", glog.size(), 1);
    if (glog.size() == 1) chk("t032_grant_idx", glog[0], 1);
    run(10);
    chk("t032_y", vlog_y.size() == 1 ? vlog_y[0] : 8'hxx, 8'd42);

`ifdef MUL_ARB_TIMEOUT_EN
    // Stub never answers: watchdog abort.
    do_reset();
    stub_off = 1;
    set_op(2, 8'h11, 8'h22);
    run(TMO + 10);
    chk("t033_count", vlog_idx.size(), 1);
    if (vlog_idx.size() == 1) chk("t033_y", vlog_y[0], 8'h00);
    stub_off = 0;
`endif

    // Randomized traffic with random request drops and mul_ready gaps.
    do_reset();
    rnd_mode = 1;
    run(400);
    rnd_mode  = 0;
    mul_ready = 1'b1;
    run(80);
    chk("rnd_balance", glog.size(), vlog_idx.size());
    chk("rnd_activity", glog.size() > 10, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
